// File: rtl/reorder_buffer_pkg.sv
// Shared LC-3b types and reorder-buffer entry layout.
package reorder_buffer_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000, op_add  = 4'b0001, op_ldb  = 4'b0010, op_stb  = 4'b0011,
    op_jsr  = 4'b0100, op_and  = 4'b0101, op_ldw  = 4'b0110, op_stw  = 4'b0111,
    op_rti  = 4'b1000, op_not  = 4'b1001, op_ldi  = 4'b1010, op_sti  = 4'b1011,
    op_jmp  = 4'b1100, op_shf  = 4'b1101, op_lea  = 4'b1110, op_trap = 4'b1111
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;
  typedef logic [2:0] rob_tag;

  localparam int ROB_TAG_W  = 3;
  localparam int ROB_DEPTH  = 2 ** ROB_TAG_W;
  localparam int ROB_DATA_W = 16;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    lc3b_opcode            opcode;
    lc3b_reg               dest;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry;

endpackage

// File: rtl/reorder_buffer_ptr.sv
// Wrapping ring pointer used for the ROB head and tail.
// Build option ROB_FLUSH_EN adds a synchronous clear input.
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef ROB_FLUSH_EN
  input  logic         clr,
`endif
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Natural W-bit overflow gives the modulo-depth wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
`ifdef ROB_FLUSH_EN
    else if (clr) ptr <= '0;
`endif
    else if (inc) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order-retire circular reorder buffer with CDB completion and two operand read ports.
// Build option ROB_FLUSH_EN adds a flush input that empties the buffer.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  alloc_we,
  input  lc3b_opcode            alloc_opcode,
  input  lc3b_reg               alloc_dest,
  output logic [tag_width-1:0]  alloc_tag,
  output logic                  full,
  output logic                  empty,
  input  logic                  cdb_valid,
  input  logic [tag_width-1:0]  cdb_tag,
  input  logic [data_width-1:0] cdb_value,
  input  logic [tag_width-1:0]  rd_tag_a,
  input  logic [tag_width-1:0]  rd_tag_b,
  output logic                  rd_ready_a,
  output logic                  rd_ready_b,
  output logic [data_width-1:0] rd_value_a,
  output logic [data_width-1:0] rd_value_b,
  output logic                  valid_out,
  output lc3b_opcode            opcode_out,
  output lc3b_reg               dest_out,
  output logic [data_width-1:0] value_out,
  output logic [tag_width-1:0]  head_tag,
  input  logic                  RE
);

  localparam int                 DEPTH   = 2 ** tag_width;
  localparam logic [tag_width:0] DEPTH_C = (tag_width + 1)'(DEPTH);

  rob_entry               ent [DEPTH];
  logic [tag_width-1:0]   head, tail;
  logic [tag_width:0]     count;
  logic                   do_alloc, do_retire, cdb_hit;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign valid_out = ent[head].busy && ent[head].ready;
  assign do_alloc  = alloc_we && !full;
  assign do_retire = RE && valid_out;
  // busy is the pre-edge value, so a same-cycle allocate cannot be completed.
  assign cdb_hit   = cdb_valid && ent[cdb_tag].busy;

  assign alloc_tag  = tail;
  assign head_tag   = head;
  assign opcode_out = ent[head].opcode;
  assign dest_out   = ent[head].dest;
  assign value_out  = data_width'(ent[head].value);

  assign rd_ready_a = ent[rd_tag_a].busy && ent[rd_tag_a].ready;
  assign rd_ready_b = ent[rd_tag_b].busy && ent[rd_tag_b].ready;
  assign rd_value_a = data_width'(ent[rd_tag_a].value);
  assign rd_value_b = data_width'(ent[rd_tag_b].value);

  rob_ptr #(.W(tag_width)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef ROB_FLUSH_EN
    .clr   (flush),
`endif
    .inc   (do_retire),
    .ptr   (head)
  );

  rob_ptr #(.W(tag_width)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef ROB_FLUSH_EN
    .clr   (flush),
`endif
    .inc   (do_alloc),
    .ptr   (tail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
`ifdef ROB_FLUSH_EN
    else if (flush) count <= '0;
`endif
    else begin
      case ({do_alloc, do_retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data fields are reset too so head/read outputs are never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].busy  <= 1'b0;
        ent[i].ready <= 1'b0;
      end
    end
`endif
    else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_hit && cdb_tag == tag_width'(i)) begin
          ent[i].ready <= 1'b1;
          ent[i].value <= ROB_DATA_W'(cdb_value);
        end
        if (do_alloc && tail == tag_width'(i)) begin
          ent[i].busy   <= 1'b1;
          ent[i].ready  <= 1'b0;
          ent[i].opcode <= alloc_opcode;
          ent[i].dest   <= alloc_dest;
        end
        if (do_retire && head == tag_width'(i)) begin
          ent[i].busy  <= 1'b0;
          ent[i].ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; flush steps run when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
`ifdef ROB_FLUSH_EN
  logic        flush;
`endif
  logic        alloc_we;
  lc3b_opcode  alloc_opcode;
  lc3b_reg     alloc_dest;
  logic [2:0]  alloc_tag;
  logic        full, empty;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic [2:0]  rd_tag_a, rd_tag_b;
  logic        rd_ready_a, rd_ready_b;
  logic [15:0] rd_value_a, rd_value_b;
  logic        valid_out;
  lc3b_opcode  opcode_out;
  lc3b_reg     dest_out;
  logic [15:0] value_out;
  logic [2:0]  head_tag;
  logic        RE;

  int n_cmp = 0;
  int n_err = 0;

  reorder_buffer #(.data_width(16), .tag_width(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef ROB_FLUSH_EN
    .flush        (flush),
`endif
    .alloc_we     (alloc_we),
    .alloc_opcode (alloc_opcode),
    .alloc_dest   (alloc_dest),
    .alloc_tag    (alloc_tag),
    .full         (full),
    .empty        (empty),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .rd_tag_a     (rd_tag_a),
    .rd_tag_b     (rd_tag_b),
    .rd_ready_a   (rd_ready_a),
    .rd_ready_b   (rd_ready_b),
    .rd_value_a   (rd_value_a),
    .rd_value_b   (rd_value_b),
    .valid_out    (valid_out),
    .opcode_out   (opcode_out),
    .dest_out     (dest_out),
    .value_out    (value_out),
    .head_tag     (head_tag),
    .RE           (RE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input lc3b_opcode opc, input lc3b_reg d);
    alloc_we = 1'b1; alloc_opcode = opc; alloc_dest = d;
    tick();
    alloc_we = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
    tick();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; alloc_we = 1'b0; alloc_opcode = op_br; alloc_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    rd_tag_a = '0; rd_tag_b = '0; RE = 1'b0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
    tick(); tick();
    check("rst_valid",    32'(valid_out), 32'd0);
    check("rst_empty",    32'(empty), 32'd1);
    check("rst_full",     32'(full), 32'd0);
    check("rst_alloctag", 32'(alloc_tag), 32'd0);
    check("rst_headtag",  32'(head_tag), 32'd0);
    check("rst_rdready",  32'({rd_ready_a, rd_ready_b}), 32'd0);
    check("rst_value",    32'(value_out), 32'd0);
    rst_n = 1'b1;

    // fill all 8 entries, dest R1..R7,R0
    for (int i = 0; i < 8; i++) begin
      alloc_we = 1'b1; alloc_opcode = op_add; alloc_dest = lc3b_reg'((i + 1) % 8);
      #1;
      check("fill_tag", 32'(alloc_tag), 32'(i));
      tick();
    end
    alloc_we = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    alloc(op_add, 3'd2);
    check("full_refuse_tail", 32'(alloc_tag), 32'd0);
    check("full_refuse_full", 32'(full), 32'd1);

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full",  32'(full), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // out-of-order completion
    alloc(op_add, 3'd3);
    alloc(op_and, 3'd4);
    alloc(op_not, 3'd5);
    cdb(3'd2, 16'h0033);
    check("ooo_not_valid", 32'(valid_out), 32'd0);
    cdb(3'd0, 16'h0011);
    check("ooo_valid",  32'(valid_out), 32'd1);
    check("ooo_value",  32'(value_out), 32'h0011);
    check("ooo_dest",   32'(dest_out), 32'd3);
    check("ooo_opcode", 32'(opcode_out), 32'(op_add));
    rd_tag_a = 3'd2; rd_tag_b = 3'd1;
    #1;
    check("rd_a_ready", 32'(rd_ready_a), 32'd1);
    check("rd_a_value", 32'(rd_value_a), 32'h0033);
    check("rd_b_unready", 32'(rd_ready_b), 32'd0);

    // in-order retire
    cdb(3'd1, 16'h0022);
    RE = 1'b1;
    #1;
    check("ret_v0", 32'(value_out), 32'h0011);
    tick();
    check("ret_v1", 32'(value_out), 32'h0022);
    check("ret_op1", 32'(opcode_out), 32'(op_and));
    tick();
    check("ret_v2", 32'(value_out), 32'h0033);
    tick();
    RE = 1'b0;
    check("ret_empty", 32'(empty), 32'd1);
    check("ret_valid", 32'(valid_out), 32'd0);
    check("ret_head",  32'(head_tag), 32'd3);
    RE = 1'b1;
    tick();
    RE = 1'b0;
    check("re_ignored", 32'(head_tag), 32'd3);

    // CDB on an entry allocated the same cycle is dropped
    alloc_we = 1'b1; alloc_opcode = op_ldw; alloc_dest = 3'd6;
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_value = 16'h0099;
    tick();
    alloc_we = 1'b0; cdb_valid = 1'b0;
    check("same_cyc_cdb", 32'(valid_out), 32'd0);
    check("same_cyc_tail", 32'(alloc_tag), 32'd4);
    cdb(3'd3, 16'hBEEF);
    rd_tag_a = 3'd3;
    #1;
    check("lookup_ready", 32'(rd_ready_a), 32'd1);
    check("lookup_value", 32'(rd_value_a), 32'hBEEF);
    check("head_beef", 32'(value_out), 32'hBEEF);
    alloc(op_stw, 3'd7);
    alloc(op_lea, 3'd0);
    rd_tag_b = 3'd4;
    #1;
    check("lookup_unready", 32'(rd_ready_b), 32'd0);

    // CDB and retire on different entries in one cycle
    RE = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_value = 16'h0055;
    tick();
    RE = 1'b0; cdb_valid = 1'b0;
    rd_tag_a = 3'd5;
    #1;
    check("cdbret_head",  32'(head_tag), 32'd4);
    check("cdbret_ready", 32'(rd_ready_a), 32'd1);
    check("cdbret_value", 32'(rd_value_a), 32'h0055);
    cdb(3'd4, 16'h0044);
    RE = 1'b1;
    tick(); tick();
    RE = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_head",  32'(head_tag), 32'd6);
    check("drain_tail",  32'(alloc_tag), 32'd6);

    // wrap-around: tags 6,7,0,1
    for (int k = 0; k < 4; k++) begin
      alloc_we = 1'b1; alloc_opcode = op_add; alloc_dest = lc3b_reg'(k);
      #1;
      check("wrap_tag", 32'(alloc_tag), 32'((6 + k) % 8));
      tick();
    end
    alloc_we = 1'b0;
    for (int k = 0; k < 4; k++) cdb(3'((6 + k) % 8), 16'(16'h0100 + k));
    RE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("wrap_value", 32'(value_out), 32'(16'h0100 + k));
      tick();
    end
    RE = 1'b0;
    check("wrap_head",  32'(head_tag), 32'd2);
    check("wrap_empty", 32'(empty), 32'd1);

    // full ROB with alloc+retire: retire only
    for (int k = 0; k < 8; k++) alloc(op_and, lc3b_reg'(k));
    check("full2_full", 32'(full), 32'd1);
    check("full2_tail", 32'(alloc_tag), 32'd2);
    cdb(3'd2, 16'h0200);
    alloc_we = 1'b1; RE = 1'b1;
    tick();
    alloc_we = 1'b0; RE = 1'b0;
    check("fullar_full", 32'(full), 32'd0);
    check("fullar_tail", 32'(alloc_tag), 32'd2);
    check("fullar_head", 32'(head_tag), 32'd3);
    // count 7: alloc+retire keeps count
    cdb(3'd3, 16'h0300);
    alloc_we = 1'b1; RE = 1'b1;
    tick();
    alloc_we = 1'b0; RE = 1'b0;
    check("c7_tail", 32'(alloc_tag), 32'd3);
    check("c7_head", 32'(head_tag), 32'd4);
    check("c7_full", 32'(full), 32'd0);
    alloc(op_add, 3'd1);
    check("c7_then_full", 32'(full), 32'd1);

`ifdef ROB_FLUSH_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) alloc(op_add, lc3b_reg'(k));
    cdb(3'd0, 16'h0777);
    flush = 1'b1; alloc_we = 1'b1;
    tick();
    flush = 1'b0; alloc_we = 1'b0;
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_tail",  32'(alloc_tag), 32'd0);
    check("flush_head",  32'(head_tag), 32'd0);
    check("flush_valid", 32'(valid_out), 32'd0);
    tick();
    check("flush_still_empty", 32'(empty), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer feeding the write-results/commit stage. Issue allocates entries in program order at the tail. The common data bus (CDB) marks entries complete with their result value. The head entry is presented to commit with a valid flag and retired in order when commit asserts its read-enable. Two tag-indexed read ports let issue fetch operands that have finished but not yet retired.

Parameters:
data_width, 16, width of result values
tag_width, 3, ROB tag width; depth = 2**tag_width (8 entries)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
alloc_we  input  1  issue requests a new entry this cycle
alloc_opcode  input  lc3b_opcode  opcode of the allocated instruction
alloc_dest  input  lc3b_reg  destination register of the allocated instruction
alloc_tag  output  tag_width  tail index; tag of the next allocation
full  output  1  no free entry
empty  output  1  no occupied entry
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  tag_width  ROB tag being completed
cdb_value  input  data_width  result value
rd_tag_a / rd_tag_b  input  tag_width  operand lookup tags
rd_ready_a / rd_ready_b  output  1  looked-up entry is occupied and ready
rd_value_a / rd_value_b  output  data_width  value of the looked-up entry
valid_out  output  1  head entry is occupied and ready
opcode_out  output  lc3b_opcode  head opcode
dest_out  output  lc3b_reg  head destination
value_out  output  data_width  head value
head_tag  output  tag_width  head index
RE  input  1  commit retires the head this cycle

Behaviour:
- State:
  - head and tail pointers, tag_width bits each, wrapping modulo depth.
  - count register, tag_width+1 bits.
  - Per entry: busy, ready, opcode, dest, value.
- Reset (rst_n low, asynchronous):
  - head = tail = count = 0; all busy and ready bits cleared.
  - Outputs: valid_out=0, empty=1, full=0, alloc_tag=0, head_tag=0, rd_ready_*=0.
  - Data fields are don't-care, but value_out, opcode_out and dest_out are driven from entry 0 and never X after reset.
  - A reset mid-operation discards all entries immediately.
- full = (count == depth). empty = (count == 0). Both are combinational from count.
- Allocate, when alloc_we && !full:
  - At the clock edge: entry[tail] gets busy=1, ready=0, opcode, dest.
  - tail increments, wrapping from depth-1 to 0.
  - alloc_tag shows the pre-increment tail during that cycle.
  - alloc_we while full is ignored: no state change.
- CDB, when cdb_valid && entry[cdb_tag].busy:
  - At the edge: ready=1, value=cdb_value.
  - A CDB hit on a non-busy entry is ignored.
  - A CDB hit on an entry allocated in the same cycle is ignored (busy is sampled pre-edge).
- Head outputs are combinational from entry[head]. valid_out = busy && ready.
- Retire, when RE && valid_out:
  - At the edge: entry[head] busy=0 and ready=0; head increments with wrap.
  - RE while valid_out=0 is ignored.
- Simultaneous allocate and retire:
  - count unchanged.
  - full is evaluated before retire, so allocate is refused when count == depth even if a retire happens in the same cycle.
- Simultaneous CDB and retire on different entries: both take effect.
- Read ports are combinational and have no CDB bypass: a same-cycle CDB result is visible the next cycle.
- Latency:
  - Allocate to first possible valid_out: 2 cycles (allocate edge, then CDB edge).
  - CDB edge to valid_out, when the entry is at the head: 0 cycles after the edge.

Optional Feature:
ROB_FLUSH_EN
- Enabled: adds input port flush (1 bit).
  - flush high at an edge clears every busy and ready bit and sets head = tail = count = 0.
  - flush has priority over a same-cycle allocate, CDB or retire.
- Disabled: no port and no flush logic.

Decomposition:
- lc3b_types package gains:
  - rob_entry struct (busy, ready, opcode, dest, value).
  - rob_tag typedef, logic [2:0].
  - ROB_DEPTH constant.
- One natural sub-module: rob_ptr, a wrapping pointer with reset, increment enable and, under ROB_FLUSH_EN, clear. It is instantiated twice, for head and tail.

Test Plan:
- Reset, then fill: assert alloc_we for 8 cycles with dest R1..R0 wrapping → alloc_tag 0..7, full=1 after the 8th edge, and a 9th alloc_we leaves tail=0 and count=8.
- Out-of-order CDB: allocate tags 0,1,2; CDB tag 2 with 0x0033, then tag 0 with 0x0011 → valid_out=1 only after tag 0 completes, value_out=0x0011, dest_out matches entry 0.
- In-order retire: continuing, CDB tag 1 with 0x0022; hold RE for 3 cycles → value_out sequence 0x0011, 0x0022, 0x0033, then empty=1 and valid_out=0.
- Wrap-around: with head=tail=6, allocate 4 entries → tags 6,7,0,1; complete and retire all → head=2, empty=1.
- Simultaneous events:
  - Full ROB, alloc_we and RE in the same cycle → retire happens, allocate is refused, count=7.
  - At count=7, alloc_we and RE together → count stays 7.
- Operand lookup: after CDB tag 3 with 0xBEEF, rd_tag_a=3 → rd_ready_a=1, rd_value_a=0xBEEF. rd_tag_b pointing at an unready entry → rd_ready_b=0.
- ROB_FLUSH_EN build: with 5 entries live, pulse flush together with alloc_we → empty=1, alloc_tag=0, no entry allocated.
